pc_fetch_sequencer: RTL

//  Fetch sequencer for the ProgramCounter register. Drives PCWriteAddr/PCEnable and

---
 rtl/pc_fetch_sequencer_pkg.sv | 27 ++
 rtl/pc_fetch_sequencer_next_mux.sv | 30 +++
 rtl/pc_fetch_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and default geometry for the fetch sequencer and its PC-select mux.
package pc_fetch_sequencer_pkg;

  localparam int DEF_ADDRESS_LENGTH = 16;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_PC_INCR        = 1;
  localparam logic [DEF_ADDRESS_LENGTH-1:0] DEF_RESET_VECTOR = 16'h0000;

  typedef enum logic [2:0] {
    ST_VEC   = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } fetchState_e;

  // Source of the next ProgramCounter value; PC_SEL_NONE means no load this cycle.
  typedef enum logic [2:0] {
    PC_SEL_NONE   = 3'd0,
    PC_SEL_VEC    = 3'd1,
    PC_SEL_INCR   = 3'd2,
    PC_SEL_BRANCH = 3'd3,
    PC_SEL_STORED = 3'd4
  } pcSel_e;

endpackage

// File: rtl/pc_fetch_sequencer_next_mux.sv
// Combinational select of the next ProgramCounter value and its load strobe.
module pc_next_mux
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int             AW     = DEF_ADDRESS_LENGTH,
  parameter int             INCR   = DEF_PC_INCR,
  parameter logic [AW-1:0]  VECTOR = AW'(DEF_RESET_VECTOR)
) (
  input  pcSel_e          sel_i,
  input  logic [AW-1:0]   pcReadAddr_i,
  input  logic [AW-1:0]   branchTarget_i,
  input  logic [AW-1:0]   storedTarget_i,
  output logic [AW-1:0]   pcWriteAddr_o,
  output logic            pcEnable_o
);

  // The sequential increment wraps naturally at the address width.
  always_comb begin
    pcWriteAddr_o = '0;
    pcEnable_o    = 1'b1;
    case (sel_i)
      PC_SEL_VEC:    pcWriteAddr_o = VECTOR;
      PC_SEL_INCR:   pcWriteAddr_o = pcReadAddr_i + AW'(INCR);
      PC_SEL_BRANCH: pcWriteAddr_o = branchTarget_i;
      PC_SEL_STORED: pcWriteAddr_o = storedTarget_i;
      default:       pcEnable_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: loads the ProgramCounter, runs req/ack instruction fetch and
// hands each instruction to decode over valid/ready, with branch, stall and halt.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int ADDRESS_LENGTH = DEF_ADDRESS_LENGTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PC_INCR        = DEF_PC_INCR,
  parameter logic [ADDRESS_LENGTH-1:0] RESET_VECTOR = ADDRESS_LENGTH'(DEF_RESET_VECTOR)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDRESS_LENGTH-1:0] pcReadAddr_i,
  output logic [ADDRESS_LENGTH-1:0] pcWriteAddr_o,
  output logic                      pcEnable_o,
  output logic                      imemReq_o,
  output logic [ADDRESS_LENGTH-1:0] imemAddr_o,
  input  logic                      imemAck_i,
  input  logic [DATA_WIDTH-1:0]     imemData_i,
  output logic                      instrValid_o,
  output logic [DATA_WIDTH-1:0]     instrOut_o,
  output logic [ADDRESS_LENGTH-1:0] instrAddr_o,
  input  logic                      instrReady_i,
  input  logic                      branchValid_i,
  input  logic [ADDRESS_LENGTH-1:0] branchTarget_i,
  input  logic                      stall_i,
  input  logic                      halt_i,
  output logic                      halted_o
);

  fetchState_e               state_q, state_d;
  logic                      imemReq_q, imemReq_d;
  logic [ADDRESS_LENGTH-1:0] imemAddr_q, imemAddr_d;
  logic                      instrValid_q, instrValid_d;
  logic [DATA_WIDTH-1:0]     instrOut_q, instrOut_d;
  logic [ADDRESS_LENGTH-1:0] instrAddr_q, instrAddr_d;
  logic                      halted_q, halted_d;
  logic [ADDRESS_LENGTH-1:0] storedTarget_q, storedTarget_d;
  logic                      branchPend_q, branchPend_d;
  logic                      vecArmed_q;
  logic                      pcEnPrev_q;
  pcSel_e                    pcSel;
  logic                      pcEnable;

  // vecArmed_q keeps PCEnable low while reset is held; pcEnPrev_q blocks back-to-back loads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_VEC;
      imemReq_q      <= 1'b0;
      imemAddr_q     <= '0;
      instrValid_q   <= 1'b0;
      instrOut_q     <= '0;
      instrAddr_q    <= '0;
      halted_q       <= 1'b0;
      storedTarget_q <= '0;
      branchPend_q   <= 1'b0;
      vecArmed_q     <= 1'b0;
      pcEnPrev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      imemReq_q      <= imemReq_d;
      imemAddr_q     <= imemAddr_d;
      instrValid_q   <= instrValid_d;
      instrOut_q     <= instrOut_d;
      instrAddr_q    <= instrAddr_d;
      halted_q       <= halted_d;
      storedTarget_q <= storedTarget_d;
      branchPend_q   <= branchPend_d;
      vecArmed_q     <= 1'b1;
      pcEnPrev_q     <= pcEnable;
    end
  end

  always_comb begin
    state_d        = state_q;
    imemReq_d      = imemReq_q;
    imemAddr_d     = imemAddr_q;
    instrValid_d   = instrValid_q;
    instrOut_d     = instrOut_q;
    instrAddr_d    = instrAddr_q;
    storedTarget_d = storedTarget_q;
    branchPend_d   = branchPend_q;
    pcSel          = PC_SEL_NONE;
    case (state_q)
      ST_VEC: begin
        if (vecArmed_q) begin
          pcSel   = PC_SEL_VEC;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A branch right after a PC load is parked and applied on the following cycle.
        if (branchValid_i && pcEnPrev_q) begin
          storedTarget_d = branchTarget_i;
          branchPend_d   = 1'b1;
        end else if (branchValid_i || branchPend_q) begin
          if (branchValid_i) pcSel = PC_SEL_BRANCH;
          else               pcSel = PC_SEL_STORED;
          branchPend_d = 1'b0;
          state_d      = halt_i ? ST_HALT : ST_FETCH;
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (!stall_i) begin
          imemReq_d  = 1'b1;
          imemAddr_d = pcReadAddr_i;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imemAck_i) begin
          imemReq_d = 1'b0;
          if (branchValid_i) begin
            pcSel   = PC_SEL_BRANCH;
            state_d = ST_FETCH;
          end else begin
            instrValid_d = 1'b1;
            instrOut_d   = imemData_i;
            instrAddr_d  = imemAddr_q;
            state_d      = ST_HOLD;
          end
        end else if (branchValid_i) begin
          storedTarget_d = branchTarget_i;
          state_d        = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (branchValid_i || instrReady_i) begin
          if (branchValid_i) pcSel = PC_SEL_BRANCH;
          else               pcSel = PC_SEL_INCR;
          instrValid_d = 1'b0;
          state_d      = halt_i ? ST_HALT : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The stale instruction is dropped; the newest redirect target wins.
        if (imemAck_i) begin
          imemReq_d = 1'b0;
          if (branchValid_i) pcSel = PC_SEL_BRANCH;
          else               pcSel = PC_SEL_STORED;
          state_d = ST_FETCH;
        end else if (branchValid_i) begin
          storedTarget_d = branchTarget_i;
        end
      end
      ST_HALT: ;
      default: state_d = ST_VEC;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  pc_next_mux #(
    .AW     (ADDRESS_LENGTH),
    .INCR   (PC_INCR),
    .VECTOR (RESET_VECTOR)
  ) uNextMux (
    .sel_i          (pcSel),
    .pcReadAddr_i   (pcReadAddr_i),
    .branchTarget_i (branchTarget_i),
    .storedTarget_i (storedTarget_q),
    .pcWriteAddr_o  (pcWriteAddr_o),
    .pcEnable_o     (pcEnable)
  );

  assign pcEnable_o   = pcEnable;
  assign imemReq_o    = imemReq_q;
  assign imemAddr_o   = imemAddr_q;
  assign instrValid_o = instrValid_q;
  assign instrOut_o   = instrOut_q;
  assign instrAddr_o  = instrAddr_q;
  assign halted_o     = halted_q;

endmodule
